// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line input and received-byte/status outputs of the UART receiver.
// master = the side driving the line (and observing status), slave = the receiver.
interface uart_rx_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    modport master (output rx_in, input data_out, valid, busy, frame_err, parity_err);
    modport slave  (input rx_in, output data_out, valid, busy, frame_err, parity_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, glitch rejection on the start bit,
// framing-error detection and break handling (no re-arm until the line has gone high).
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic      clock,
    input  logic      reset,
    uart_rx_if.slave  rx
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic          sync1_q, sync2_q, prev_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          par_bad;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          perr_q, perr_d;
`endif

    assign rx_s = sync2_q;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    // prev_q only rises when the line really went high, so a held-low break cannot re-arm.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx.rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit must equal the XOR of the data bits.
    assign par_bad = (par_q != ^shift_q);
`else
    assign par_bad = 1'b0;
`endif

    // Next-state and output pulse logic; every sample point is mid-bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                shift_d = '0;
                if (prev_q && !rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = PARITY;
`else
                    if (idx_q == 3'd7) state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    // A low stop bit wins over a parity mismatch.
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                        perr_d = 1'b1;
`endif
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.data_out  = data_q;
    assign rx.valid     = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = perr_q;
`else
    assign rx.parity_err = 1'b0;
`endif
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 10416 at defaults).
REQ-003 clock  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 rx_in  input  1  serial line, idle high, asynchronous to clock.
REQ-006 data_out  output  8  last correctly received byte.
REQ-007 valid  output  1  one-cycle pulse, data_out updated this cycle.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 parity_err  output  1  one-cycle pulse, parity mismatch (see Configuration).

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 Frame format: 1 start (low), 8 data LSB first, optional parity, 1 stop (high).
REQ-013 States: IDLE, START, DATA, PARITY (macro only), STOP; one bit-period counter, one 3-bit bit index.
REQ-014 IDLE -> START on rx_s high-to-low transition; counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles, rx_s low -> DATA; rx_s high -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: every CLKS_PER_BIT cycles sample rx_s into shift register bit index 0..7; after bit 7 -> PARITY or STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles sample; high and no parity error -> data_out loaded, valid=1 for one cycle; low -> frame_err=1 one cycle, data_out unchanged; then IDLE.
REQ-018 valid, frame_err, parity_err SHALL never be high in the same cycle.
REQ-019 Line held low after frame error (break): IDLE SHALL NOT re-arm until rx_s has been high, then falls.
REQ-020 Back-to-back frames: new start edge accepted the cycle after returning to IDLE; no bytes lost at BAUD with one stop bit.
REQ-021 Latency: valid asserts (9.5+P)*CLKS_PER_BIT +3 ±1 cycles after rx_in falling edge, P=1 with parity else 0.

Reset
REQ-022 reset=0 SHALL immediately force IDLE, counters 0, shift register 0, data_out=8'h00, valid=0, busy=0, frame_err=0, parity_err=0, synchronizer flops=1.
REQ-023 Reset mid-frame SHALL discard the partial byte; next complete frame after release received normally.

Configuration
REQ-024 Macro UART_RX_PARITY_EN: when defined, PARITY state inserted after DATA, one bit period, even parity checked over 8 data bits.
REQ-025 With macro: mismatch -> parity_err pulse at stop-sample cycle, valid suppressed, data_out unchanged; stop-bit low takes priority (frame_err only).
REQ-026 Without macro: no PARITY state, parity_err tied 0, DATA -> STOP directly.

Verification
REQ-027 Defaults, send 8'hBA, stop high -> data_out=8'hBA, valid one cycle ~99000 cycles after start edge, busy low after.
REQ-028 rx_in low 1000 cycles then high -> no valid/frame_err, busy returns low within CLKS_PER_BIT/2+3 cycles.
REQ-029 Send 8'h55 with stop bit low -> frame_err one cycle, data_out keeps previous value, no valid.
REQ-030 reset=0 during data bit 4 of 8'hA5, release, send 8'h3C -> outputs zero during reset, then data_out=8'h3C valid once.
REQ-031 Back-to-back 8'h00 then 8'hFF, no idle gap -> two valid pulses, values 00 then FF.
REQ-032 UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 (wrong) -> parity_err pulse, no valid; with parity 1 -> valid, data_out=8'h07.
